// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator: an oversample tick from an integer+fraction divisor,
// a bit-rate tick every OSR ticks, and divisor updates applied only at period boundaries.
module baud_gen_frac #(
    parameter int unsigned DVSR_W   = 16,
    parameter int unsigned FRAC_W   = 4,
    parameter int unsigned OSR      = 16,
    parameter int unsigned DVSR_RST = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              sync,
    input  logic              load,
    input  logic [DVSR_W-1:0] dvsr_int,
    input  logic [FRAC_W-1:0] dvsr_frac,
    output logic              tick,
    output logic              bit_tick,
    output logic              upd_pend
);

    localparam int unsigned     OS_W    = (OSR > 1) ? $clog2(OSR) : 1;
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OSR - 1);

    logic [DVSR_W:0]   cnt_q, cnt_d;
    logic [DVSR_W:0]   lim_q, lim_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [OS_W-1:0]   os_cnt_q, os_cnt_d;
    logic [DVSR_W-1:0] act_int_q, act_int_d;
    logic [FRAC_W-1:0] act_frac_q, act_frac_d;
    logic [DVSR_W-1:0] sh_int_q, sh_int_d;
    logic [FRAC_W-1:0] sh_frac_q, sh_frac_d;
    logic              upd_pend_q, upd_pend_d;
    logic              tick_q, tick_d;
    logic              bit_tick_q, bit_tick_d;

    logic              wrap;
    logic              os_last;
    logic [DVSR_W-1:0] nxt_int;
    logic [FRAC_W-1:0] nxt_frac;
    logic [FRAC_W:0]   acc_sum;
    logic [DVSR_W:0]   lim_wrap;

    assign wrap    = en && !sync && (cnt_q == lim_q);
    assign os_last = (os_cnt_q == OS_LAST);

    // Divisor governing the period that starts at this wrap: a coincident load is
    // bypassed straight in, otherwise a pending shadow, otherwise the active pair.
    always_comb begin
        nxt_int  = act_int_q;
        nxt_frac = act_frac_q;
        if (load) begin
            nxt_int  = dvsr_int;
            nxt_frac = dvsr_frac;
        end else if (upd_pend_q) begin
            nxt_int  = sh_int_q;
            nxt_frac = sh_frac_q;
        end
    end

    // Fraction carry stretches the next period by one cycle.
    assign acc_sum  = {1'b0, acc_q} + {1'b0, nxt_frac};
    assign lim_wrap = {1'b0, nxt_int} + {{DVSR_W{1'b0}}, acc_sum[FRAC_W]};

    always_comb begin
        cnt_d      = cnt_q;
        lim_d      = lim_q;
        acc_d      = acc_q;
        os_cnt_d   = os_cnt_q;
        act_int_d  = act_int_q;
        act_frac_d = act_frac_q;
        sh_int_d   = sh_int_q;
        sh_frac_d  = sh_frac_q;
        upd_pend_d = upd_pend_q;
        tick_d     = wrap;
        bit_tick_d = wrap && os_last;

        if (sync) begin
            cnt_d    = '0;
            acc_d    = '0;
            os_cnt_d = '0;
            if (load) begin
                act_int_d  = dvsr_int;
                act_frac_d = dvsr_frac;
                sh_int_d   = dvsr_int;
                sh_frac_d  = dvsr_frac;
                upd_pend_d = 1'b0;
                lim_d      = {1'b0, dvsr_int};
            end else begin
                lim_d = {1'b0, act_int_q};
            end
        end else if (!en) begin
            // Counters are frozen, so a new divisor can take effect at once.
            if (load) begin
                act_int_d  = dvsr_int;
                act_frac_d = dvsr_frac;
                sh_int_d   = dvsr_int;
                sh_frac_d  = dvsr_frac;
                upd_pend_d = 1'b0;
                lim_d      = {1'b0, dvsr_int};
            end
        end else if (wrap) begin
            cnt_d      = '0;
            acc_d      = acc_sum[FRAC_W-1:0];
            lim_d      = lim_wrap;
            os_cnt_d   = os_last ? '0 : os_cnt_q + 1'b1;
            act_int_d  = nxt_int;
            act_frac_d = nxt_frac;
            upd_pend_d = 1'b0;
            if (load) begin
                sh_int_d  = dvsr_int;
                sh_frac_d = dvsr_frac;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
            if (load) begin
                sh_int_d   = dvsr_int;
                sh_frac_d  = dvsr_frac;
                upd_pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            lim_q      <= (DVSR_W + 1)'(DVSR_RST);
            acc_q      <= '0;
            os_cnt_q   <= '0;
            act_int_q  <= DVSR_W'(DVSR_RST);
            act_frac_q <= '0;
            sh_int_q   <= DVSR_W'(DVSR_RST);
            sh_frac_q  <= '0;
            upd_pend_q <= 1'b0;
            tick_q     <= 1'b0;
            bit_tick_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            lim_q      <= lim_d;
            acc_q      <= acc_d;
            os_cnt_q   <= os_cnt_d;
            act_int_q  <= act_int_d;
            act_frac_q <= act_frac_d;
            sh_int_q   <= sh_int_d;
            sh_frac_q  <= sh_frac_d;
            upd_pend_q <= upd_pend_d;
            tick_q     <= tick_d;
            bit_tick_q <= bit_tick_d;
        end
    end

    assign tick     = tick_q;
    assign bit_tick = bit_tick_q;
    assign upd_pend = upd_pend_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Scoreboard bench for baud_gen_frac: a period-length model predicts tick/bit_tick edges
// and upd_pend per cycle; a negedge monitor pops and compares.
module tb_baud_gen_frac;

    localparam int unsigned DVSR_W   = 8;
    localparam int unsigned FRAC_W   = 4;
    localparam int unsigned OSR      = 16;
    localparam int unsigned DVSR_RST = 3;
    localparam int          FRAC_ONE = 1 << FRAC_W;

    logic              clk;
    logic              reset;
    logic              en;
    logic              sync;
    logic              load;
    logic [DVSR_W-1:0] dvsr_int;
    logic [FRAC_W-1:0] dvsr_frac;
    logic              tick;
    logic              bit_tick;
    logic              upd_pend;

    baud_gen_frac #(
        .DVSR_W  (DVSR_W),
        .FRAC_W  (FRAC_W),
        .OSR     (OSR),
        .DVSR_RST(DVSR_RST)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .sync     (sync),
        .load     (load),
        .dvsr_int (dvsr_int),
        .dvsr_frac(dvsr_frac),
        .tick     (tick),
        .bit_tick (bit_tick),
        .upd_pend (upd_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int c;
        bit b;
    } ev_t;

    ev_t exp_ticks[$];
    ev_t exp_pend[$];
    int  cyc   = 0;
    int  total = 0;
    int  bad   = 0;

    // Model: current period length, cycles elapsed in it, fraction phase, tick count.
    int m_i, m_f, m_si, m_sf, m_len, m_el, m_a, m_nt;
    bit m_pend, m_last_w, m_last_bit;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_i = DVSR_RST;  m_f = 0;  m_si = DVSR_RST;  m_sf = 0;
        m_len = DVSR_RST + 1;  m_el = 0;  m_a = 0;  m_nt = 0;
        m_pend = 0;  m_last_w = 0;  m_last_bit = 0;
        exp_ticks.delete();
        exp_pend.delete();
    endtask

    // Predict the effect of the coming edge from the inputs now being driven.
    task automatic model_edge();
        m_last_w   = 0;
        m_last_bit = 0;
        if (sync) begin
            if (load) begin
                m_i = int'(dvsr_int);  m_f = int'(dvsr_frac);  m_pend = 0;
            end
            m_len = m_i + 1;  m_el = 0;  m_a = 0;  m_nt = 0;
        end else if (!en) begin
            if (load) begin
                m_i = int'(dvsr_int);  m_f = int'(dvsr_frac);  m_pend = 0;
                m_len = m_i + 1;
            end
        end else if (m_el == m_len - 1) begin
            if (load) begin
                m_i = int'(dvsr_int);  m_f = int'(dvsr_frac);
            end else if (m_pend) begin
                m_i = m_si;  m_f = m_sf;
            end
            m_pend = 0;
            m_a = m_a + m_f;
            m_len = m_i + 1 + ((m_a >= FRAC_ONE) ? 1 : 0);
            m_a = m_a % FRAC_ONE;
            m_el = 0;
            m_last_w = 1;
            m_last_bit = ((m_nt % OSR) == OSR - 1);
            m_nt++;
            exp_ticks.push_back('{cyc + 1, m_last_bit});
        end else begin
            m_el++;
            if (load) begin
                m_si = int'(dvsr_int);  m_sf = int'(dvsr_frac);  m_pend = 1;
            end
        end
        exp_pend.push_back('{cyc + 1, m_pend});
    endtask

    task automatic cycle(input logic e, input logic s, input logic l,
                         input logic [DVSR_W-1:0] di, input logic [FRAC_W-1:0] df);
        en = e;  sync = s;  load = l;  dvsr_int = di;  dvsr_frac = df;
        model_edge();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic async_reset();
        #2 reset = 1'b0;
        #1;
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_bit_tick", 32'(bit_tick), 32'd0);
        chk("rst_upd_pend", 32'(upd_pend), 32'd0);
        model_reset();
        en = 1'b0;  sync = 1'b0;  load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (reset) begin
            if (exp_pend.size() > 0 && exp_pend[0].c == cyc) begin
                e = exp_pend.pop_front();
                chk("upd_pend", 32'(upd_pend), 32'(e.b));
            end
            while (exp_ticks.size() > 0 && exp_ticks[0].c < cyc) begin
                e = exp_ticks.pop_front();
                chk("tick_missed", 32'd0, 32'd1);
            end
            if (exp_ticks.size() > 0 && exp_ticks[0].c == cyc) begin
                e = exp_ticks.pop_front();
                chk("tick", 32'(tick), 32'd1);
                chk("bit_tick", 32'(bit_tick), 32'(e.b));
            end else begin
                chk("tick_idle", 32'(tick), 32'd0);
                chk("bit_tick_idle", 32'(bit_tick), 32'd0);
            end
        end
    end

    initial begin
        reset = 1'b1;  en = 1'b0;  sync = 1'b0;  load = 1'b0;
        dvsr_int = '0;  dvsr_frac = '0;
        model_reset();
        #1 reset = 1'b0;
        #1;
        chk("init_tick", 32'(tick), 32'd0);
        chk("init_bit_tick", 32'(bit_tick), 32'd0);
        chk("init_upd_pend", 32'(upd_pend), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Reset-value divisor first, then a frozen-counter load of 4.
        run(30);
        cycle(1'b0, 1'b1, 1'b0, '0, '0);
        cycle(1'b0, 1'b0, 1'b1, 8'd4, 4'd0);
        run(200);

        // Half-cycle fraction: periods 5,5,6,5,6...
        cycle(1'b1, 1'b1, 1'b1, 8'd4, 4'd8);
        run(400);

        // Mid-period load of 9 waits for the boundary.
        for (int k = 0; k < 20 && m_el != 1; k++) run(1);
        cycle(1'b1, 1'b0, 1'b1, 8'd9, 4'd0);
        run(60);

        // Sync two cycles after a tick with divisor 7.
        cycle(1'b1, 1'b1, 1'b1, 8'd7, 4'd0);
        run(3);
        for (int k = 0; k < 20 && !m_last_w; k++) run(1);
        run(2);
        cycle(1'b1, 1'b1, 1'b0, '0, '0);
        run(200);

        // Enable dropped for 13 cycles mid-period.
        for (int k = 0; k < 20 && m_el != 3; k++) run(1);
        for (int k = 0; k < 13; k++) cycle(1'b0, 1'b0, 1'b0, '0, '0);
        run(40);

        // Divisor 0/0 ticks every cycle; reset while bit_tick is high.
        cycle(1'b1, 1'b1, 1'b1, 8'd0, 4'd0);
        run(20);
        for (int k = 0; k < 40 && !m_last_bit; k++) run(1);
        async_reset();
        run(10);

        // Reset while a load is pending.
        cycle(1'b1, 1'b1, 1'b1, 8'd20, 4'd0);
        run(3);
        cycle(1'b1, 1'b0, 1'b1, 8'd6, 4'd3);
        run(2);
        async_reset();
        run(20);

        // All-ones integer with maximum fraction exercises the widened limit.
        cycle(1'b1, 1'b1, 1'b1, 8'hFF, 4'hF);
        run(1100);

        for (int k = 0; k < 3000; k++) begin
            logic e, s, l;
            logic [DVSR_W-1:0] di;
            logic [FRAC_W-1:0] df;
            e  = ($urandom_range(0, 9) != 0);
            s  = ($urandom_range(0, 99) == 0);
            l  = ($urandom_range(0, 29) == 0);
            di = DVSR_W'($urandom_range(0, 12));
            df = FRAC_W'($urandom);
            // A frozen-counter load only at a period start keeps cnt within the new limit.
            if (l && !e && !s && m_el != 0) l = 1'b0;
            cycle(e, s, l, di, df);
        end

        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b0, '0, '0);
        chk("drain", 32'(exp_ticks.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/baud_gen_frac.md
# baud_gen_frac

Parametrised fractional baud-rate generator, the successor to our integer `dvsr` tick generator for the UART transmitter and receiver. It produces an oversampling `tick` and a derived `bit_tick` from a divisor with integer and fractional parts. New divisors are loaded glitch-free at period boundaries. A `sync` input re-phases all counters, for example on receiver start-bit detection.

## Interface
Parameters:
- `DVSR_W`, default 16: width of the integer divisor.
- `FRAC_W`, default 4: width of the fractional divisor, in units of 1/2^FRAC_W cycle.
- `OSR`, default 16: oversampling ratio, ≥2. It is the number of `tick`s per `bit_tick`.
- `DVSR_RST`, default 0: reset value of the active integer divisor.

Ports:
- `clk` in 1: clock.
- `reset` in 1: **asynchronous, active-low** reset. The name is kept for codebase consistency; the polarity is low-true.
- `en` in 1: count enable.
- `sync` in 1: synchronous phase restart.
- `load` in 1: one-cycle strobe that captures `dvsr_int`/`dvsr_frac`.
- `dvsr_int` in DVSR_W: integer divisor.
- `dvsr_frac` in FRAC_W: fractional divisor.
- `tick` out 1: oversample tick, one cycle wide, registered.
- `bit_tick` out 1: bit-rate tick, one cycle wide, registered, coincident with every OSR-th `tick`.
- `upd_pend` out 1: a loaded divisor is waiting for the next boundary.

## Operation
- Registers:
  - `cnt` (DVSR_W+1 bits).
  - `lim` (DVSR_W+1 bits).
  - `acc` (FRAC_W bits).
  - `os_cnt` (0..OSR-1).
  - Active divisor `act_int`/`act_frac`.
  - Shadow divisor `sh_int`/`sh_frac`.
  - `upd_pend`, `tick`, `bit_tick`.
- Wrap event W = `en && !sync && cnt==lim`.
- Counting:
  - When `en` is high and W is false, `cnt` increments.
  - On W, `cnt` goes to 0.
  - When `en` is low, all state holds.
- On W, the following updates happen:
  - `{c, acc} <= acc + f`, where f is the active fraction in effect for the next period.
  - `lim <= i + c`, where i is the active integer in effect for the next period.
  - `os_cnt` increments and wraps OSR-1→0.
- Tick period is `lim+1` cycles. The average tick period is `dvsr_int + 1 + dvsr_frac/2^FRAC_W` cycles. The baud rate is f_clk / (that value × OSR).
- Divisor update:
  - `load` captures the inputs into the shadow registers and sets `upd_pend`.
  - If `en` is low, the shadow is copied to active immediately on the next edge, and `lim` is set to the new `dvsr_int`.
  - Otherwise the shadow is copied at the next W, and that W uses the new values for `i`/`f`. `upd_pend` clears at that point.
  - `load` coincident with W: the input values are bypassed straight into that W's computation, and `upd_pend` stays 0.
  - `load` coincident with `sync`: the new values are applied immediately.
- `sync`:
  - Priority is below reset and above everything else.
  - Sets `cnt`=0, `acc`=0, `os_cnt`=0, `lim`=`act_int` (or the loaded value, if `load` is coincident).
  - The next `tick` falls `lim+1` cycles later.
- `dvsr_int`=0 with `dvsr_frac`=0: `tick` is asserted every enabled cycle. This is legal.
- The `lim` width of DVSR_W+1 prevents overflow when `dvsr_int` is all-ones and c=1.

## Timing
- Reset values:
  - `cnt`=0, `acc`=0, `os_cnt`=0.
  - `lim`=`act_int`=`sh_int`=DVSR_RST.
  - `act_frac`=`sh_frac`=0.
  - `tick`=0, `bit_tick`=0, `upd_pend`=0.
- Reset is asserted asynchronously. Deassertion is synchronised externally. Reset mid-period discards all phase and any pending load.
- `tick` is registered: it is high in the cycle after the W edge, i.e. `tick <= W`.
- `bit_tick <= W && os_cnt==OSR-1`.
- From reset release with `en`=1, the first `tick` goes high at cycle DVSR_RST+1, counting the first enabled edge as cycle 1.
- `en` low:
  - `tick` and `bit_tick` are forced low on the next edge.
  - Phase is preserved, and resumes exactly when `en` returns high.
- `sync` cycle: `tick` and `bit_tick` are low on the next edge.

## Test plan
- Reset, `en`=1, `dvsr_int`=4, `dvsr_frac`=0, load while `en`=0 -> `tick` every 5 cycles; `bit_tick` every 80 cycles, aligned with a `tick`.
- `dvsr_int`=4, `dvsr_frac`=8 -> first period 5, then periods alternate 5,5,6,5,6…; any 32 consecutive periods after the first total exactly 176 cycles.
- Mid-run `load` of `dvsr_int`=9 -> `upd_pend`=1 until the next `tick` boundary; the current period finishes at the old length; following periods are 10 cycles; no short or long glitch period.
- `sync` asserted 2 cycles after a `tick` with `dvsr_int`=7 -> no tick for the remainder; next `tick` exactly 8 cycles after the sync edge; `os_cnt` restarts, so `bit_tick` comes 16 ticks later.
- `en` dropped for 13 cycles mid-period, then restored -> `tick` low throughout; the next tick is delayed by exactly 13 cycles.
- `dvsr_int`=0, `dvsr_frac`=0, then async reset (`reset`=0) mid-stream -> `tick` every cycle; all outputs go to 0 immediately on reset; `upd_pend` clears.
